tpu_result_deskew: RTL and testbench

//  Downstream of tpu_top: reads one result matrix from a 512b C SRAM, where it is stored

---
 rtl/tpu_result_deskew.sv | 169 ++++++++++++++++
 tb/tb_tpu_result_deskew.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tpu_result_deskew.sv
// Result de-skew stage: reads one anti-diagonal-packed result matrix from the C SRAM,
// rebuilds it as a square buffer and streams it out one row per valid/ready handshake.
module tpu_result_deskew #(
    parameter int ARRAY_SIZE = 16,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                               clk,
    input  logic                               srstn,
    input  logic                               start,
    output logic                               busy,
    output logic                               done,
    output logic [ADDR_WIDTH-1:0]              sram_raddr,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0]   sram_rdata,
    output logic                               row_valid,
    input  logic                               row_ready,
    output logic [$clog2(ARRAY_SIZE)-1:0]      row_idx,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0]   row_data
);

    localparam int N        = ARRAY_SIZE;
    localparam int NUM_DIAG = 2 * N - 1;
    localparam int DIAG_W   = $clog2(NUM_DIAG);
    localparam int ROW_W    = $clog2(N);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_DIAG - 1);
    localparam logic [DIAG_W-1:0]     LAST_DIAG = DIAG_W'(NUM_DIAG - 1);
    localparam logic [ROW_W-1:0]      LAST_ROW  = ROW_W'(N - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_OUT,
        S_DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   raddr_q, raddr_d;
    logic                    cap_vld_q, cap_vld_d;   // sram_rdata holds a diagonal this cycle
    logic [DIAG_W-1:0]       cap_k_q, cap_k_d;       // which diagonal sram_rdata holds
    logic [ROW_W-1:0]        row_idx_q, row_idx_d;

    // Reassembled matrix, row-major: mem[i][j] = C[i][j]
    logic [DATA_WIDTH-1:0]   mem [N][N];

    // Per-row write port for the diagonal currently on sram_rdata
    logic                    wr_en  [N];
    logic [ROW_W-1:0]        wr_col [N];
    logic [DATA_WIDTH-1:0]   wr_val [N];

    // Next-state logic: read sequencing, capture tracking and row handshake
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d   = state_q;
        raddr_d   = raddr_q;
        row_idx_d = row_idx_q;
        cap_vld_d = (state_q == S_READ);
        cap_k_d   = raddr_q[DIAG_W-1:0];

        unique case (state_q)
            S_IDLE: begin
                raddr_d   = '0;
                row_idx_d = '0;
                if (start) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (raddr_q == LAST_ADDR) begin
                    state_d = S_DRAIN;
                    raddr_d = '0;
                end else begin
                    raddr_d = raddr_q + ADDR_WIDTH'(1);
                end
            end
            S_DRAIN: begin
                // The last diagonal lands in the buffer at the end of this cycle
                if (cap_vld_q && (cap_k_q == LAST_DIAG)) begin
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (row_ready) begin
                    if (row_idx_q == LAST_ROW) begin
                        state_d   = S_DONE;
                        row_idx_d = '0;
                    end else begin
                        row_idx_d = row_idx_q + ROW_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control registers, cleared asynchronously
    always_ff @(posedge clk or negedge srstn) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!srstn) begin
            state_q   <= S_IDLE;
            raddr_q   <= '0;
            cap_vld_q <= 1'b0;
            cap_k_q   <= '0;
            row_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            raddr_q   <= raddr_d;
            cap_vld_q <= cap_vld_d;
            cap_k_q   <= cap_k_d;
            row_idx_q <= row_idx_d;
        end
    end

    // Unpack diagonal k: row i owns element C[i][k-i] when 0 <= k-i < N. The packer
    // right-aligns the n_k valid elements, so that element sits in slot
    // i + (N-1) - min(k, N-1).
    always_comb begin
        int k;
        int k_clamp;
        int slot;
        k       = int'(cap_k_q);
        k_clamp = (k < N - 1) ? k : N - 1;
        slot    = 0;
        for (int i = 0; i < N; i++) begin
            wr_en[i]  = 1'b0;
            wr_col[i] = '0;
            wr_val[i] = '0;
            if (cap_vld_q && (k >= i) && (k - i <= N - 1)) begin
                slot      = i + (N - 1) - k_clamp;
                wr_en[i]  = 1'b1;
                wr_col[i] = ROW_W'(k - i);
                wr_val[i] = sram_rdata[slot*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Matrix buffer write
    always_ff @(posedge clk) begin
        // NOTE: the buffer has no reset; every element is rewritten on each pass before it is read.
        for (int i = 0; i < N; i++) begin
            if (wr_en[i]) begin
                mem[i][wr_col[i]] <= wr_val[i];
            end
        end
    end

    // Output row mux; zero whenever no row is being offered
    always_comb begin
        row_data = '0;
        if (state_q == S_OUT) begin
            for (int j = 0; j < N; j++) begin
                row_data[j*DATA_WIDTH +: DATA_WIDTH] = mem[row_idx_q][j];
            end
        end
    end

    assign busy       = (state_q == S_READ) || (state_q == S_DRAIN) || (state_q == S_OUT);
    assign done       = (state_q == S_DONE);
    assign row_valid  = (state_q == S_OUT);
    assign sram_raddr = raddr_q;
    assign row_idx    = row_idx_q;

endmodule

// File: tb/tb_tpu_result_deskew.sv
// Self-checking bench for tpu_result_deskew: behavioural C SRAM, row scoreboard,
// directed passes covering latency, backpressure, ignored starts, mid-pass reset and
// special FP32 bit patterns.
module tb_tpu_result_deskew;

    localparam int N  = 16;
    localparam int DW = 32;
    localparam int ND = 2 * N - 1;

    typedef struct {
        logic [3:0]      idx;
        logic [N*DW-1:0] data;
    } row_t;

    logic            clk;
    logic            srstn;
    logic            start;
    logic            busy;
    logic            done;
    logic [5:0]      sram_raddr;
    logic [N*DW-1:0] sram_rdata;
    logic            row_valid;
    logic            row_ready;
    logic [3:0]      row_idx;
    logic [N*DW-1:0] row_data;

    logic [N*DW-1:0] sram [ND];
    logic [DW-1:0]   mat  [N][N];
    row_t            sb[$];

    int n_vec  = 0;
    int n_fail = 0;
    int first_valid_c;
    int done_c;

    tpu_result_deskew #(
        .ARRAY_SIZE(16),
        .DATA_WIDTH(32),
        .ADDR_WIDTH(6)
    ) dut (
        .clk       (clk),
        .srstn     (srstn),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .sram_raddr(sram_raddr),
        .sram_rdata(sram_rdata),
        .row_valid (row_valid),
        .row_ready (row_ready),
        .row_idx   (row_idx),
        .row_data  (row_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read C SRAM: data appears the cycle after the address
    always @(posedge clk) begin
        sram_rdata <= (sram_raddr < 6'(ND)) ? sram[sram_raddr] : '0;
    end

    task automatic chk(input string tag, input logic [N*DW-1:0] obs, input logic [N*DW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Fill mat (kind 0 tag, 1/2 random, 3 random with special corners) and pack the SRAM
    task automatic load(input int kind);
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (kind == 0) mat[i][j] = {16'h0000, 8'(i), 8'(j)};
                else           mat[i][j] = $urandom;
            end
        end
        if (kind == 3) begin
            mat[0][0]     = 32'h7FC0_0001;
            mat[0][N-1]   = 32'h8000_0000;
            mat[N-1][0]   = 32'h7F80_0000;
            mat[N-1][N-1] = 32'h0000_0001;
        end
        for (int k = 0; k < ND; k++) begin
            logic [N*DW-1:0] w;
            int nk;
            int imin;
            for (int s = 0; s < N; s++) w[s*DW +: DW] = $urandom;
            nk   = (k + 1 < ND - k) ? k + 1 : ND - k;
            imin = (k - N + 1 > 0) ? k - N + 1 : 0;
            for (int p = 0; p < nk; p++) begin
                w[(N - nk + p)*DW +: DW] = mat[imin + p][k - imin - p];
            end
            sram[k] = w;
        end
        for (int i = 0; i < N; i++) begin
            row_t r;
            r.idx = 4'(i);
            for (int j = 0; j < N; j++) r.data[j*DW +: DW] = mat[i][j];
            sb.push_back(r);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},  512'(busy),       512'(0));
        chk({tag, "_done"},  512'(done),       512'(0));
        chk({tag, "_valid"}, 512'(row_valid),  512'(0));
        chk({tag, "_raddr"}, 512'(sram_raddr), 512'(0));
        chk({tag, "_idx"},   512'(row_idx),    512'(0));
        chk({tag, "_data"},  row_data,         512'(0));
    endtask

    // One pass. mode 0: ready high; mode 1: 5-cycle stall at row 3 then alternating.
    // inj: extra start pulses at cycles 10 and 40. abort_at>0: reset at that cycle.
    task automatic run_pass(input int mode, input bit inj, input int abort_at);
        int c;
        int stall_n;
        bit fin;
        bit prev_stall;
        logic [3:0] prev_idx;
        logic [N*DW-1:0] prev_data;
        first_valid_c = -1;
        done_c        = -1;
        stall_n       = 0;
        fin           = 1'b0;
        prev_stall    = 1'b0;
        prev_idx      = '0;
        prev_data     = '0;
        start         = 1'b1;
        row_ready     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        c     = 1;
        while (!fin && c < 300) begin
            if (c == abort_at) begin
                srstn = 1'b0;
                #1;
                chk_all_zero("mid_reset");
                @(posedge clk);
                #1;
                srstn = 1'b1;
                sb.delete();
                return;
            end
            if (mode == 1) begin
                if (row_valid && row_idx == 4'd3 && stall_n < 5) begin
                    row_ready = 1'b0;
                    stall_n++;
                end else if (stall_n >= 5) begin
                    row_ready = ((c % 2) == 0);
                end else begin
                    row_ready = 1'b1;
                end
            end
            start = inj && (c == 10 || c == 40);
            if (c <= 31) chk("raddr", 512'(sram_raddr), 512'(c - 1));
            if (mode == 0) chk("busy", 512'(busy), 512'(c <= 48));
            else           chk("busy", 512'(busy), 512'(!done));
            if (row_valid && first_valid_c < 0) first_valid_c = c;
            if (prev_stall) begin
                chk("stall_valid", 512'(row_valid), 512'(1));
                chk("stall_idx",   512'(row_idx),   512'(prev_idx));
                chk("stall_data",  row_data,        prev_data);
            end
            if (row_valid && row_ready) begin
                n_vec++;
                assert (sb.size() != 0) else begin
                    n_fail++;
                    $error("FAIL extra_row: observed row %0d expected none", row_idx);
                end
                if (sb.size() != 0) begin
                    row_t e;
                    e = sb.pop_front();
                    chk("row_idx",  512'(row_idx), 512'(e.idx));
                    chk("row_data", row_data,      e.data);
                end
            end
            prev_stall = row_valid && !row_ready;
            prev_idx   = row_idx;
            prev_data  = row_data;
            if (done) begin
                done_c = c;
                fin    = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                c++;
            end
        end
        start     = 1'b0;
        row_ready = 1'b1;
        n_vec++;
        assert (fin) else begin
            n_fail++;
            $error("FAIL timeout: observed no done after %0d cycles expected done", c);
        end
        chk("rows_left", 512'(sb.size()), 512'(0));
    endtask

    task automatic idle_check(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            chk("idle_busy",  512'(busy),      512'(0));
            chk("idle_done",  512'(done),      512'(0));
            chk("idle_valid", 512'(row_valid), 512'(0));
        end
    endtask

    initial begin
        srstn     = 1'b0;
        start     = 1'b0;
        row_ready = 1'b0;
        for (int k = 0; k < ND; k++) sram[k] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        srstn = 1'b1;
        @(posedge clk);
        #1;

        // Tag pattern with ready high: data, read addresses and latency
        load(0);
        run_pass(0, 1'b0, 0);
        chk("first_valid", 512'(first_valid_c), 512'(33));
        chk("done_cycle",  512'(done_c),        512'(49));
        idle_check(2);

        // Backpressure
        load(1);
        run_pass(1, 1'b0, 0);
        idle_check(2);

        // Starts during a pass are ignored; then a fresh pass with new contents
        load(1);
        run_pass(0, 1'b1, 0);
        chk("inj_done_cycle", 512'(done_c), 512'(49));
        idle_check(5);
        load(2);
        run_pass(0, 1'b0, 0);
        chk("pass3_done_cycle", 512'(done_c), 512'(49));
        idle_check(2);

        // Reset during READ, then a full fresh pass
        load(0);
        run_pass(0, 1'b0, 20);
        load(0);
        run_pass(0, 1'b0, 0);
        chk("post_reset_first_valid", 512'(first_valid_c), 512'(33));
        idle_check(2);

        // Special FP32 bit patterns at the corners
        load(3);
        run_pass(0, 1'b0, 0);
        idle_check(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
